// File: rtl/i2c_pkg.sv
// Shared definitions for the serial RX slave and its TX master:
// the state encoding, line levels and default frame/ack geometry.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STOP,
    ACK,
    WAIT_IDLE
  } rx_state_e;

  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  localparam int   DEF_WIDTH   = 32;
  localparam int   DEF_ACK_LEN = 2;

  // One-hot select of buffer 0/1, gated by an enable.
  function automatic logic [1:0] ptrMask(input logic ptr, input logic en);
    if (!en)
      return 2'b00;
    return ptr ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rx_shift.sv
// MSB-first deserializer: shifts one bit per enabled clock and flags the
// cycle on which the final bit of a WIDTH-bit word is taken in.
module rx_shift
  import i2c_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_word <= {r_word[WIDTH-2:0], bit_in};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // done marks the shift that completes the word, so the caller can leave
  // its data state on the same edge the last bit lands.
  assign done = en && (r_cnt == CW'(WIDTH - 1));
  assign word = r_word;

endmodule

// File: rtl/i2c_rx_slave.sv
// Receive-side slave: frames serial data into a ping-pong pair of buffers,
// acknowledges good frames and lets a local consumer pop words in order.
module i2c_rx_slave
  import i2c_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ACK_LEN    = DEF_ACK_LEN,
  parameter bit IDLE_LEVEL = STOP_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RXin,
  output logic             Ackrecvd,
  input  logic             read,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             RXBuff0,
  output logic             RXBuff1,
  output logic             overrun,
  output logic             frameErr
);

  localparam logic       StartLvl = (IDLE_LEVEL == STOP_BIT) ? START_BIT : STOP_BIT;
  localparam logic [3:0] AckLast  = 4'(ACK_LEN - 1);

  rx_state_e        r_state;
  rx_state_e        w_stateNext;
  logic             r_rxin;
  logic [3:0]       r_ackCnt;
  logic [WIDTH-1:0] r_buf [2];
  logic [1:0]       r_full;
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic             r_overrun;
  logic             r_frameErr;

  logic             w_shiftEn;
  logic             w_shiftClr;
  logic             w_shiftDone;
  logic [WIDTH-1:0] w_word;
  logic             w_commit;
  logic             w_overrunSet;
  logic             w_frameErrSet;
  logic             w_pop;
  logic [1:0]       w_postFull;

  // The line is registered once before the FSM sees it; this is what places
  // the commit and ack WIDTH+2 cycles after the start bit is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rxin <= IDLE_LEVEL;
    else
      r_rxin <= RXin;
  end

  rx_shift #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_shiftEn),
    .clr    (w_shiftClr),
    .bit_in (r_rxin),
    .word   (w_word),
    .done   (w_shiftDone)
  );

  assign w_pop      = read && (r_full != 2'b00);
  assign w_postFull = r_full & ~ptrMask(r_rdPtr, w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_stateNext;
  end

  // Occupancy is judged after any same-cycle pop, so a read can make room
  // for the frame committing on that edge.
  always_comb begin
    w_stateNext   = r_state;
    w_shiftEn     = 1'b0;
    w_shiftClr    = 1'b0;
    w_commit      = 1'b0;
    w_overrunSet  = 1'b0;
    w_frameErrSet = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rxin == StartLvl) begin
          w_shiftClr  = 1'b1;
          w_stateNext = DATA;
        end
      end
      DATA: begin
        w_shiftEn = 1'b1;
        if (w_shiftDone)
          w_stateNext = STOP;
      end
      STOP: begin
        if (r_rxin == IDLE_LEVEL) begin
          if (!w_postFull[r_wrPtr]) begin
            w_commit    = 1'b1;
            w_stateNext = ACK;
          end else begin
            w_overrunSet = 1'b1;
            w_stateNext  = IDLE;
          end
        end else begin
          w_frameErrSet = 1'b1;
          w_stateNext   = WAIT_IDLE;
        end
      end
      ACK: begin
        if (r_ackCnt == AckLast)
          w_stateNext = IDLE;
      end
      WAIT_IDLE: begin
        if (r_rxin == IDLE_LEVEL)
          w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ackCnt <= '0;
    else if (r_state != ACK)
      r_ackCnt <= '0;
    else
      r_ackCnt <= r_ackCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_full     <= 2'b00;
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_full     <= w_postFull | ptrMask(r_wrPtr, w_commit);
      r_frameErr <= w_frameErrSet;
      if (w_commit) begin
        r_buf[r_wrPtr] <= w_word;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop)
        r_rdPtr <= ~r_rdPtr;
      if (w_overrunSet)
        r_overrun <= 1'b1;
    end
  end

  assign Ackrecvd  = (r_state == ACK);
  assign dataOut   = r_buf[r_rdPtr];
  assign dataValid = |r_full;
  assign RXBuff0   = r_full[0];
  assign RXBuff1   = r_full[1];
  assign overrun   = r_overrun;
  assign frameErr  = r_frameErr;

endmodule

// File: tb/tb_i2c_rx_slave.sv
// Directed self-checking bench for i2c_rx_slave: drives framed serial words
// on RXin at the falling edge and checks handshake and buffer state there.
module tb_i2c_rx_slave;

  logic        clk;
  logic        rst_n;
  logic        RXin;
  logic        Ackrecvd;
  logic        read;
  logic [31:0] dataOut;
  logic        dataValid;
  logic        RXBuff0;
  logic        RXBuff1;
  logic        overrun;
  logic        frameErr;

  int compCount = 0;
  int errCount  = 0;

  i2c_rx_slave #(.WIDTH(32), .ACK_LEN(2), .IDLE_LEVEL(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RXin      (RXin),
    .Ackrecvd  (Ackrecvd),
    .read      (read),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .RXBuff0   (RXBuff0),
    .RXBuff1   (RXBuff1),
    .overrun   (overrun),
    .frameErr  (frameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic b);
    @(negedge clk);
    RXin = b;
  endtask

  task automatic idleLine(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1);
  endtask

  task automatic sendFrame(input logic [31:0] d, input logic stopBit);
    applyStimulus(1'b0);
    for (int i = 31; i >= 0; i--)
      applyStimulus(d[i]);
    applyStimulus(stopBit);
  endtask

  // Four idle cycles after the stop bit: ack must be low, high, high, low.
  task automatic expectAck(input string tag);
    applyStimulus(1'b1);
    checkOutput({tag, "_ack_early"}, Ackrecvd, 1'b0);
    applyStimulus(1'b1);
    checkOutput({tag, "_ack_1"}, Ackrecvd, 1'b1);
    applyStimulus(1'b1);
    checkOutput({tag, "_ack_2"}, Ackrecvd, 1'b1);
    applyStimulus(1'b1);
    checkOutput({tag, "_ack_end"}, Ackrecvd, 1'b0);
  endtask

  task automatic expectNoAck(input string tag);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      checkOutput({tag, "_noack"}, Ackrecvd, 1'b0);
    end
  endtask

  task automatic popWord(input string tag, input logic [31:0] exp);
    @(negedge clk);
    RXin = 1'b1;
    checkOutput({tag, "_valid"}, dataValid, 1'b1);
    checkOutput({tag, "_data"}, dataOut, exp);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    RXin  = 1'b1;
    read  = 1'b0;
    #1;
    checkOutput("rst_ack", Ackrecvd, 1'b0);
    checkOutput("rst_valid", dataValid, 1'b0);
    checkOutput("rst_buff0", RXBuff0, 1'b0);
    checkOutput("rst_buff1", RXBuff1, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);
    checkOutput("rst_frameerr", frameErr, 1'b0);
    checkOutput("rst_data", dataOut, 32'd0);
    idleLine(2);
    rst_n = 1'b1;
    idleLine(3);

    $display("[TB] single frame 2");
    sendFrame(32'd2, 1'b1);
    applyStimulus(1'b1);
    checkOutput("t1_ack_early", Ackrecvd, 1'b0);
    checkOutput("t1_buff0_early", RXBuff0, 1'b0);
    applyStimulus(1'b1);
    checkOutput("t1_ack_1", Ackrecvd, 1'b1);
    checkOutput("t1_buff0", RXBuff0, 1'b1);
    checkOutput("t1_buff1", RXBuff1, 1'b0);
    checkOutput("t1_data", dataOut, 32'd2);
    applyStimulus(1'b1);
    checkOutput("t1_ack_2", Ackrecvd, 1'b1);
    applyStimulus(1'b1);
    checkOutput("t1_ack_end", Ackrecvd, 1'b0);
    popWord("t1_pop", 32'd2);
    checkOutput("t1_buff0_after", RXBuff0, 1'b0);
    checkOutput("t1_valid_after", dataValid, 1'b0);
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checkOutput("t1_empty_read_valid", dataValid, 1'b0);

    $display("[TB] back-to-back 8, 67 then overrun with 5");
    sendFrame(32'd8, 1'b1);
    expectAck("t2a");
    sendFrame(32'd67, 1'b1);
    expectAck("t2b");
    checkOutput("t2_buff0", RXBuff0, 1'b1);
    checkOutput("t2_buff1", RXBuff1, 1'b1);
    sendFrame(32'd5, 1'b1);
    applyStimulus(1'b1);
    checkOutput("t3_overrun_early", overrun, 1'b0);
    applyStimulus(1'b1);
    checkOutput("t3_overrun", overrun, 1'b1);
    checkOutput("t3_ack", Ackrecvd, 1'b0);
    expectNoAck("t3");
    checkOutput("t3_overrun_sticky", overrun, 1'b1);
    popWord("t3_pop_first", 32'd8);
    popWord("t3_pop_second", 32'd67);
    checkOutput("t3_valid_after", dataValid, 1'b0);

    $display("[TB] frame error then recovery");
    sendFrame(32'd67, 1'b0);
    applyStimulus(1'b0);
    checkOutput("t4_ferr_early", frameErr, 1'b0);
    applyStimulus(1'b0);
    checkOutput("t4_ferr", frameErr, 1'b1);
    checkOutput("t4_ack", Ackrecvd, 1'b0);
    applyStimulus(1'b0);
    checkOutput("t4_ferr_pulse", frameErr, 1'b0);
    checkOutput("t4_valid", dataValid, 1'b0);
    expectNoAck("t4");
    sendFrame(32'd2, 1'b1);
    expectAck("t4r");
    checkOutput("t4r_buff1", RXBuff1, 1'b1);
    checkOutput("t4r_buff0", RXBuff0, 1'b0);
    checkOutput("t4r_data", dataOut, 32'd2);

    $display("[TB] full pair with read on commit cycle");
    sendFrame(32'd67, 1'b1);
    expectAck("t5a");
    checkOutput("t5_full_pair", {RXBuff1, RXBuff0}, 2'b11);
    sendFrame(32'd9, 1'b1);
    applyStimulus(1'b1);
    read = 1'b1;
    applyStimulus(1'b1);
    read = 1'b0;
    checkOutput("t5_ack", Ackrecvd, 1'b1);
    checkOutput("t5_overrun", overrun, 1'b1);
    checkOutput("t5_full_after", {RXBuff1, RXBuff0}, 2'b11);
    idleLine(3);
    popWord("t5_pop_first", 32'd67);
    popWord("t5_pop_second", 32'd9);

    $display("[TB] reset mid-frame");
    sendFrame(32'd2, 1'b1);
    expectAck("t6a");
    checkOutput("t6_buff0_pre", RXBuff0, 1'b1);
    applyStimulus(1'b0);
    for (int i = 31; i >= 22; i--)
      applyStimulus(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ack", Ackrecvd, 1'b0);
    checkOutput("t6_rst_buff0", RXBuff0, 1'b0);
    checkOutput("t6_rst_valid", dataValid, 1'b0);
    checkOutput("t6_rst_overrun", overrun, 1'b0);
    checkOutput("t6_rst_data", dataOut, 32'd0);
    RXin = 1'b1;
    idleLine(2);
    rst_n = 1'b1;
    idleLine(3);
    sendFrame(32'd2, 1'b1);
    expectAck("t6b");
    checkOutput("t6_buff0", RXBuff0, 1'b1);
    checkOutput("t6_buff1", RXBuff1, 1'b0);
    checkOutput("t6_overrun", overrun, 1'b0);
    popWord("t6_pop", 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
